// File: rtl/uart_rx_sampler.sv
// UART receive sampler: prescaled oversampling tick, 3-sample majority vote,
// LSB-first deserialiser with a valid/ready output register and error pulses.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rxd_sync,
  output logic [DATA_BITS-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t                 state, state_n;
  logic [PRESCALE_W-1:0]  tcnt, pre_q;
  logic                   tick;
  logic [SW-1:0]          scnt, scnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   s1, s1_n, s2, s2_n;
  logic                   pend, pend_n;
  logic                   ferr_n;
  logic                   maj, dec, last;

  // prescale is latched on reload so a change never truncates a tick
  assign tick = (tcnt == pre_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      pre_q <= '0;
    end else if (tick) begin
      tcnt  <= '0;
      pre_q <= prescale;
    end else begin
      tcnt  <= tcnt + PRESCALE_W'(1);
    end
  end

  assign maj  = (s1 & s2) | (s1 & rxd_sync) | (s2 & rxd_sync);
  assign dec  = (scnt == SW'(H + 1));
  assign last = (scnt == SW'(OVERSAMPLE - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    idx_n   = idx;
    shreg_n = shreg;
    s1_n    = s1;
    s2_n    = s2;
    pend_n  = 1'b0;
    ferr_n  = 1'b0;
    if (tick) begin
      scnt_n = scnt + SW'(1);
      if (scnt == SW'(H - 1)) s1_n = rxd_sync;
      if (scnt == SW'(H))     s2_n = rxd_sync;
      unique case (state)
        IDLE: begin
          scnt_n = '0;
          if (!rxd_sync) begin
            state_n = START;
            scnt_n  = SW'(1);
          end
        end
        START: begin
          if (dec && maj) begin
            state_n = IDLE;
            scnt_n  = '0;
          end else if (last) begin
            state_n = DATA;
            scnt_n  = '0;
            idx_n   = '0;
          end
        end
        DATA: begin
          if (dec) begin
            shreg_n = shreg >> 1;
            shreg_n[DATA_BITS-1] = maj;
          end
          if (last) begin
            scnt_n = '0;
            if (idx == IW'(DATA_BITS - 1))
              state_n = STOP;
            else
              idx_n = idx + IW'(1);
          end
        end
        STOP: begin
          if (dec) begin
            scnt_n = '0;
            if (maj) begin
              pend_n  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end
        end
        BRK: begin
          scnt_n = '0;
          if (rxd_sync) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          scnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= '0;
      idx   <= '0;
      shreg <= '0;
      s1    <= 1'b1;
      s2    <= 1'b1;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      s1    <= s1_n;
      s2    <= s2_n;
      pend  <= pend_n;
    end
  end

  // shreg is untouched until the next frame's DATA, so deliver straight from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      overrun   <= pend && m_valid && !m_ready;
      if (pend && (!m_valid || m_ready)) begin
        m_data  <= shreg;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
